// File: rtl/bus_rr_router_if.sv
`default_nettype none
// ============================================================================
//  Module      : bus_rr_router_if
//  Description : Bus bundle between the round-robin router and the per-device
//                FIFOs: pending flags, FIFO head words, pop/push strobes,
//                broadcast data lanes and the router's status/counters.
//  Revision    : 1.0  initial release
// ============================================================================
interface bus_rr_router_if #(
    parameter int drvrs   = 4,
    parameter int pckg_sz = 16
);
    logic [drvrs-1:0]              pndng;
    logic [drvrs-1:0][pckg_sz-1:0] D_pop;
    logic [drvrs-1:0]              pop;
    logic [drvrs-1:0]              push;
    logic [drvrs-1:0][pckg_sz-1:0] D_push;
    logic                          busy;
    logic                          drop;
    logic [15:0]                   pkt_cnt;
    logic [15:0]                   drop_cnt;

    // Router side.
    modport master (
        input  pndng, D_pop,
        output pop, push, D_push, busy, drop, pkt_cnt, drop_cnt
    );

    // FIFO / environment side.
    modport slave (
        output pndng, D_pop,
        input  pop, push, D_push, busy, drop, pkt_cnt, drop_cnt
    );
endinterface
`default_nettype wire

// File: rtl/bus_rr_router.sv
`default_nettype none
// ============================================================================
//  Module      : bus_rr_router
//  Description : Round-robin bus controller. Grants one pending device FIFO,
//                pops its head packet, decodes the 8-bit destination ID from
//                the header and pushes the packet to the destination FIFO
//                (or to every other device on broadcast). Invalid IDs are
//                dropped. Delivered and dropped packets are counted.
//  Revision    : 1.0  initial release
// ============================================================================
module bus_rr_router #(
    parameter int         drvrs     = 4,
    parameter int         pckg_sz   = 16,
    parameter logic [7:0] broadcast = 8'hFF
) (
    input  logic            clk,
    input  logic            reset,
    bus_rr_router_if.master bus
);
    localparam int c_IDX_W = $clog2(drvrs);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POP  = 2'd1,
        ST_PUSH = 2'd2
    } state_t;

    state_t               state_q,    state_d;
    logic [c_IDX_W-1:0]   last_g_q,   last_g_d;
    logic [drvrs-1:0]     pop_q,      pop_d;
    logic [pckg_sz-1:0]   pkt_q,      pkt_d;
    logic [15:0]          pkt_cnt_q,  pkt_cnt_d;
    logic [15:0]          drop_cnt_q, drop_cnt_d;

    logic                 w_grant_vld;
    logic [c_IDX_W-1:0]   w_grant_idx;
    int                   w_scan;
    logic [7:0]           w_dest;
    logic                 w_is_uni;
    logic                 w_is_bc;
    logic [drvrs-1:0]     w_push;
    logic                 w_drop;

    // Round-robin search: first pending device starting after the last grant.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_scan      = 0;
        for (int i = 0; i < drvrs; i++) begin
            w_scan = int'(last_g_q) + 1 + i;
            if (w_scan >= drvrs) begin
                w_scan = w_scan - drvrs;
            end
            if (!w_grant_vld && bus.pndng[c_IDX_W'(w_scan)]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = c_IDX_W'(w_scan);
            end
        end
    end

    // Header decode and push/drop strobes, active only in the PUSH cycle.
    // The source of the held packet is last_g_q: it cannot change before IDLE.
    always_comb begin
        w_dest   = pkt_q[pckg_sz-1 -: 8];
        w_is_uni = (int'(w_dest) < drvrs);
        w_is_bc  = (w_dest == broadcast);
        w_push   = '0;
        w_drop   = 1'b0;
        if (state_q == ST_PUSH) begin
            if (w_is_uni) begin
                w_push[c_IDX_W'(w_dest)] = 1'b1;
            end else if (w_is_bc) begin
                w_push           = '1;
                w_push[last_g_q] = 1'b0;
            end else begin
                w_drop = 1'b1;
            end
        end
    end

    // Next-state logic: grant in IDLE, capture in POP, count in PUSH.
    always_comb begin
        state_d    = state_q;
        last_g_d   = last_g_q;
        pop_d      = '0;
        pkt_d      = pkt_q;
        pkt_cnt_d  = pkt_cnt_q;
        drop_cnt_d = drop_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (w_grant_vld) begin
                    pop_d[w_grant_idx] = 1'b1;
                    last_g_d           = w_grant_idx;
                    state_d            = ST_POP;
                end
            end
            ST_POP: begin
                // FIFOs are first-word-fall-through: head is valid this cycle.
                pkt_d   = bus.D_pop[last_g_q];
                state_d = ST_PUSH;
            end
            ST_PUSH: begin
                if (w_is_uni || w_is_bc) begin
                    pkt_cnt_d = pkt_cnt_q + 16'd1;
                end else begin
                    drop_cnt_d = drop_cnt_q + 16'd1;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; reset aborts any transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            last_g_q   <= c_IDX_W'(drvrs - 1);
            pop_q      <= '0;
            pkt_q      <= '0;
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            last_g_q   <= last_g_d;
            pop_q      <= pop_d;
            pkt_q      <= pkt_d;
            pkt_cnt_q  <= pkt_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus.pop      = pop_q;
    assign bus.push     = w_push;
    assign bus.drop     = w_drop;
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.D_push   = {drvrs{pkt_q}};
    assign bus.pkt_cnt  = pkt_cnt_q;
    assign bus.drop_cnt = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_rr_router.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_rr_router
//  Description : Self-checking bench for bus_rr_router. Device FIFOs are
//                modelled as queues; expected grants, strobes and counters
//                come from a transaction-level round-robin model.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_bus_rr_router;
    localparam int N = 4;
    localparam int W = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bus_rr_router_if #(.drvrs(N), .pckg_sz(W)) bus ();

    bus_rr_router #(.drvrs(N), .pckg_sz(W), .broadcast(8'hFF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [W-1:0] fifo_q [N][$];
    int total = 0;
    int bad   = 0;
    int last_g;
    int exp_pkt_cnt;
    int exp_drop_cnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.pndng[i] = (fifo_q[i].size() != 0);
            bus.D_pop[i] = (fifo_q[i].size() != 0) ? fifo_q[i][0] : '0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drive();
    endtask

    function automatic logic [W-1:0] rand_pkt();
        int sel;
        logic [7:0] dest;
        sel = $urandom_range(0, 5);
        if (sel < 4)       dest = 8'(sel);
        else if (sel == 4) dest = 8'hFF;
        else               dest = 8'($urandom_range(4, 254));
        return {dest, 8'($urandom_range(0, 255))};
    endfunction

    task automatic model_reset();
        last_g       = N - 1;
        exp_pkt_cnt  = 0;
        exp_drop_cnt = 0;
    endtask

    // One full transaction starting in an IDLE cycle with something pending.
    task automatic serve(output int g_out, input bit inject);
        int g;
        logic [W-1:0] pkt;
        logic [N-1:0] exp_pop;
        logic [N-1:0] exp_push;
        logic [7:0]   dest;
        bit           exp_drop;
        g = -1;
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (last_g + k) % N;
            if (g < 0 && fifo_q[c].size() != 0) g = c;
        end
        g_out = g;
        tick();
        exp_pop = '0;
        exp_pop[g] = 1'b1;
        check("pop", 64'(bus.pop), 64'(exp_pop));
        check("busy_pop", 64'(bus.busy), 64'd1);
        check("push_in_pop", 64'(bus.push), 64'd0);
        pkt = fifo_q[g].pop_front();
        if (inject) fifo_q[$urandom_range(0, N-1)].push_back(rand_pkt());
        tick();
        dest     = pkt[W-1 -: 8];
        exp_push = '0;
        exp_drop = 1'b0;
        if (int'(dest) < N) begin
            exp_push[dest[1:0]] = 1'b1;
            exp_pkt_cnt++;
        end else if (dest == 8'hFF) begin
            exp_push    = '1;
            exp_push[g] = 1'b0;
            exp_pkt_cnt++;
        end else begin
            exp_drop = 1'b1;
            exp_drop_cnt++;
        end
        check("push", 64'(bus.push), 64'(exp_push));
        check("drop", 64'(bus.drop), 64'(exp_drop));
        check("d_push", 64'(bus.D_push), {pkt, pkt, pkt, pkt});
        check("pop_in_push", 64'(bus.pop), 64'd0);
        tick();
        check("busy_idle", 64'(bus.busy), 64'd0);
        check("pkt_cnt", 64'(bus.pkt_cnt), 64'(exp_pkt_cnt & 16'hFFFF));
        check("drop_cnt", 64'(bus.drop_cnt), 64'(exp_drop_cnt & 16'hFFFF));
        check("drop_after", 64'(bus.drop), 64'd0);
        last_g = g;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int g;
        int exp_order [6];
        exp_order = '{0, 1, 3, 0, 1, 3};
        reset = 1'b1;
        drive();
        do_reset();

        // Reset values and idle behaviour.
        check("rst_pop", 64'(bus.pop), 64'd0);
        check("rst_push", 64'(bus.push), 64'd0);
        check("rst_drop", 64'(bus.drop), 64'd0);
        check("rst_dpush", 64'(bus.D_push), 64'd0);
        check("rst_pkt_cnt", 64'(bus.pkt_cnt), 64'd0);
        check("rst_drop_cnt", 64'(bus.drop_cnt), 64'd0);
        for (int i = 0; i < 3; i++) begin
            check("idle_busy", 64'(bus.busy), 64'd0);
            tick();
        end

        // Unicast 0 -> 2.
        fifo_q[0].push_back(16'h0214);
        drive();
        serve(g, 1'b0);
        check("uni_grant", 64'(g), 64'd0);

        // Round-robin with pndng held at 1011.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            fifo_q[0].push_back({8'(k), 8'h10});
            fifo_q[1].push_back({8'(3 - k), 8'h20});
            fifo_q[3].push_back({8'((k + 1) % 4), 8'h30});
        end
        drive();
        for (int k = 0; k < 6; k++) begin
            serve(g, 1'b0);
            check("rr_order", 64'(g), 64'(exp_order[k]));
        end
        for (int k = 0; k < 3; k++) serve(g, 1'b0);

        // Broadcast from device 1.
        fifo_q[1].push_back(16'hFFAA);
        drive();
        serve(g, 1'b0);

        // Invalid ID from device 2.
        fifo_q[2].push_back(16'h0533);
        drive();
        serve(g, 1'b0);

        // Reset in the PUSH cycle aborts the transaction.
        fifo_q[0].push_back(16'h0214);
        drive();
        tick();
        void'(fifo_q[0].pop_front());
        tick();
        check("abort_push_live", 64'(bus.push), 64'h4);
        reset = 1'b1;
        tick();
        check("abort_push", 64'(bus.push), 64'd0);
        check("abort_pop", 64'(bus.pop), 64'd0);
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_pkt_cnt", 64'(bus.pkt_cnt), 64'd0);
        check("abort_drop_cnt", 64'(bus.drop_cnt), 64'd0);
        reset = 1'b0;
        model_reset();
        tick();

        // Loopback 0 -> 0.
        fifo_q[0].push_back(16'h0014);
        drive();
        serve(g, 1'b0);

        // Random traffic with arrivals during POP/PUSH.
        for (int it = 0; it < 60; it++) begin
            int n;
            n = $urandom_range(0, 3);
            for (int j = 0; j < n; j++) fifo_q[$urandom_range(0, N-1)].push_back(rand_pkt());
            drive();
            if (bus.pndng != '0) begin
                serve(g, 1'($urandom_range(0, 1)));
            end else begin
                tick();
                check("rand_idle_busy", 64'(bus.busy), 64'd0);
            end
        end
        for (int it = 0; it < 400; it++) begin
            if (bus.pndng == '0) break;
            serve(g, 1'b0);
        end
        check("drained", 64'(bus.pndng), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
